// File: rtl/bus_arbiter_if.sv
// ---------------------------------------------------------------------------
// bus_arbiter_if
//
// Bundles every handshake and bus signal of the two-master bus arbiter:
//   - clear                  : pipeline flush from the core
//   - if_*                   : instruction-fetch master (read-only requests)
//   - ma_*                   : memory-access master (reads and writes)
//   - rsp_*                  : response data/error shared by both masters
//   - mem_a_* / mem_d_*      : downstream request and response channels
//
// Modports:
//   slave  : the arbiter's view (takes master requests and memory responses,
//            drives grants, responses and the downstream request channel)
//   master : the environment's view (cores plus memory model), the mirror
//            image of slave
// ---------------------------------------------------------------------------
interface bus_arbiter_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
);
    localparam int MASK_W = DATA_W / 8;

    logic              clear;

    logic              if_request;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;

    logic              ma_request;
    logic              ma_we;
    logic [ADDR_W-1:0] ma_addr;
    logic [DATA_W-1:0] ma_wdata;
    logic [MASK_W-1:0] ma_mask;
    logic              ma_gnt;
    logic              ma_rvalid;

    logic [DATA_W-1:0] rsp_data;
    logic              rsp_err;

    logic              mem_a_valid;
    logic              mem_a_ready;
    logic              mem_a_we;
    logic [ADDR_W-1:0] mem_a_addr;
    logic [DATA_W-1:0] mem_a_wdata;
    logic [MASK_W-1:0] mem_a_mask;

    logic              mem_d_valid;
    logic [DATA_W-1:0] mem_d_data;
    logic              mem_d_error;

    modport slave (
        input  clear,
        input  if_request, if_addr,
        output if_gnt, if_rvalid,
        input  ma_request, ma_we, ma_addr, ma_wdata, ma_mask,
        output ma_gnt, ma_rvalid,
        output rsp_data, rsp_err,
        output mem_a_valid, mem_a_we, mem_a_addr, mem_a_wdata, mem_a_mask,
        input  mem_a_ready,
        input  mem_d_valid, mem_d_data, mem_d_error
    );

    modport master (
        output clear,
        output if_request, if_addr,
        input  if_gnt, if_rvalid,
        output ma_request, ma_we, ma_addr, ma_wdata, ma_mask,
        input  ma_gnt, ma_rvalid,
        input  rsp_data, rsp_err,
        input  mem_a_valid, mem_a_we, mem_a_addr, mem_a_wdata, mem_a_mask,
        output mem_a_ready,
        output mem_d_valid, mem_d_data, mem_d_error
    );
endinterface

// File: rtl/bus_arbiter.sv
// ---------------------------------------------------------------------------
// bus_arbiter
//
// Arbitrates an instruction-fetch master (if) and a memory-access master (ma)
// onto a single downstream request/response bus, with exactly one
// transaction outstanding at a time (IDLE -> ADDR -> DATA -> IDLE).
//
// Ports:
//   clk  : single clock, all state on the rising edge
//   rst  : asynchronous, active-high reset
//   bus  : bus_arbiter_if.slave bundle (clear, if_*, ma_*, rsp_*, mem_a_*,
//          mem_d_*)
//
// Timing: a grant in cycle T raises mem_a_valid in T+1; the earliest
// response (mem_d_valid in T+2) produces rvalid and registered rsp_* in T+3,
// which is also the earliest cycle the next grant can happen.
// ---------------------------------------------------------------------------
module bus_arbiter #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic clk,
    input  logic rst,
    bus_arbiter_if.slave bus
);
    localparam int MASK_W = DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        DATA
    } state_t;

    state_t            state;
    logic              owner_is_if;
    logic              drop;
    logic [2:0]        starve_cnt;

    logic              grant_if;
    logic              grant_ma;

    logic              if_rvalid_q;
    logic              ma_rvalid_q;
    logic [DATA_W-1:0] rsp_data_q;
    logic              rsp_err_q;
    logic              a_valid_q;
    logic              a_we_q;
    logic [ADDR_W-1:0] a_addr_q;
    logic [DATA_W-1:0] a_wdata_q;
    logic [MASK_W-1:0] a_mask_q;

    // Grant decision. The grant pulse has to appear in the same cycle the
    // request is captured, so it is the one combinational output. The memory
    // master normally wins; once it has won four times over a waiting fetch,
    // the fetch gets the next slot. A flush blocks fetch grants only. The
    // decision is gated with rst so no grant leaks out while in reset.
    always_comb begin
        grant_if = 1'b0;
        grant_ma = 1'b0;
        if (!rst && state == IDLE) begin
            if (bus.if_request && !bus.clear &&
                (starve_cnt == 3'd4 || !bus.ma_request)) begin
                grant_if = 1'b1;
            end else if (bus.ma_request) begin
                grant_ma = 1'b1;
            end
        end
    end

    // Transaction FSM with all registered outputs. Request fields are latched
    // at grant time so the downstream request stays stable while stalled.
    // A flush during an in-flight fetch does not abort the bus transaction;
    // it only marks the response to be swallowed. rsp_* are loaded on every
    // accepted response (dropped or not) and otherwise hold their value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            owner_is_if <= 1'b0;
            drop        <= 1'b0;
            starve_cnt  <= 3'd0;
            if_rvalid_q <= 1'b0;
            ma_rvalid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            a_valid_q   <= 1'b0;
            a_we_q      <= 1'b0;
            a_addr_q    <= '0;
            a_wdata_q   <= '0;
            a_mask_q    <= '0;
        end else begin
            if_rvalid_q <= 1'b0;
            ma_rvalid_q <= 1'b0;
            case (state)
                IDLE: begin
                    drop <= 1'b0;
                    if (grant_if) begin
                        owner_is_if <= 1'b1;
                        a_we_q      <= 1'b0;
                        a_addr_q    <= bus.if_addr;
                        a_wdata_q   <= '0;
                        a_mask_q    <= '1;
                        a_valid_q   <= 1'b1;
                        starve_cnt  <= 3'd0;
                        state       <= ADDR;
                    end else if (grant_ma) begin
                        owner_is_if <= 1'b0;
                        a_we_q      <= bus.ma_we;
                        a_addr_q    <= bus.ma_addr;
                        a_wdata_q   <= bus.ma_wdata;
                        a_mask_q    <= bus.ma_mask;
                        a_valid_q   <= 1'b1;
                        if (bus.if_request && starve_cnt != 3'd4) begin
                            starve_cnt <= starve_cnt + 3'd1;
                        end
                        state       <= ADDR;
                    end
                end
                ADDR: begin
                    if (owner_is_if && bus.clear) begin
                        drop <= 1'b1;
                    end
                    if (bus.mem_a_ready) begin
                        a_valid_q <= 1'b0;
                        state     <= DATA;
                    end
                end
                DATA: begin
                    if (owner_is_if && bus.clear) begin
                        drop <= 1'b1;
                    end
                    if (bus.mem_d_valid) begin
                        rsp_data_q  <= bus.mem_d_data;
                        rsp_err_q   <= bus.mem_d_error;
                        if_rvalid_q <= owner_is_if && !drop && !bus.clear;
                        ma_rvalid_q <= !owner_is_if;
                        drop        <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.if_gnt      = grant_if;
    assign bus.ma_gnt      = grant_ma;
    assign bus.if_rvalid   = if_rvalid_q;
    assign bus.ma_rvalid   = ma_rvalid_q;
    assign bus.rsp_data    = rsp_data_q;
    assign bus.rsp_err     = rsp_err_q;
    assign bus.mem_a_valid = a_valid_q;
    assign bus.mem_a_we    = a_we_q;
    assign bus.mem_a_addr  = a_addr_q;
    assign bus.mem_a_wdata = a_wdata_q;
    assign bus.mem_a_mask  = a_mask_q;
endmodule

// File: tb/tb_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_bus_arbiter
//
// Directed bench for bus_arbiter. Each cycle the bench steps 2 time units
// past the rising edge, drives inputs, waits 1 more unit and compares the
// DUT outputs with hand-computed values. The control outputs are compared
// as one 5-bit vector {if_gnt, ma_gnt, mem_a_valid, if_rvalid, ma_rvalid}.
// ---------------------------------------------------------------------------
module tb_bus_arbiter;
    localparam int ADDR_W = 64;
    localparam int DATA_W = 64;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    logic [4:0] ctl_obs;
    logic [4:0] t3_exp [6];

    bus_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    assign ctl_obs = {bus.if_gnt, bus.ma_gnt, bus.mem_a_valid,
                      bus.if_rvalid, bus.ma_rvalid};

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case the directed sequence ever stalls.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic nextCycle();
        @(posedge clk);
        #2;
    endtask

    task automatic applyStimulus(input logic if_req, input logic ma_req,
                                 input logic clr, input logic a_ready,
                                 input logic d_valid);
        bus.if_request  = if_req;
        bus.ma_request  = ma_req;
        bus.clear       = clr;
        bus.mem_a_ready = a_ready;
        bus.mem_d_valid = d_valid;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_fail++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic checkCtl(input string tag, input logic [4:0] expected);
        checkOutput(tag, 64'(ctl_obs), 64'(expected));
    endtask

    // Directed sequence: reset, single fetch, ma-vs-if priority, starvation
    // limit, flush handling, downstream stall, reset mid-transaction.
    initial begin
        n_checks = 0;
        n_fail   = 0;
        t3_exp   = '{5'b01000, 5'b01001, 5'b01001, 5'b01001, 5'b10001, 5'b01010};
        rst      = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        bus.if_addr     = '0;
        bus.ma_we       = 1'b0;
        bus.ma_addr     = '0;
        bus.ma_wdata    = '0;
        bus.ma_mask     = '0;
        bus.mem_d_data  = '0;
        bus.mem_d_error = 1'b0;

        nextCycle();
        nextCycle();
        #1;
        checkCtl("reset_ctl", 5'b00000);
        checkOutput("reset_rsp_data", bus.rsp_data, 64'h0);
        checkOutput("reset_a_addr", bus.mem_a_addr, 64'h0);
        rst = 1'b0;

        $display("[TB] single fetch");
        nextCycle();
        bus.if_addr = 64'h8000_0000;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        #1 checkCtl("t1_gnt", 5'b10000);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        #1 checkCtl("t1_a_valid", 5'b00100);
        checkOutput("t1_a_addr", bus.mem_a_addr, 64'h8000_0000);
        checkOutput("t1_a_mask", 64'(bus.mem_a_mask), 64'hFF);
        checkOutput("t1_a_we", 64'(bus.mem_a_we), 64'h0);
        nextCycle();
        bus.mem_d_data = 64'h13;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        #1 checkCtl("t1_data_state", 5'b00000);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1 checkCtl("t1_rvalid", 5'b00010);
        checkOutput("t1_rsp_data", bus.rsp_data, 64'h13);
        nextCycle();
        #1 checkCtl("t1_after", 5'b00000);
        checkOutput("t1_rsp_hold", bus.rsp_data, 64'h13);

        $display("[TB] simultaneous requests");
        nextCycle();
        bus.if_addr  = 64'h8000_0004;
        bus.ma_we    = 1'b1;
        bus.ma_addr  = 64'h1000;
        bus.ma_wdata = 64'hDEAD_BEEF;
        bus.ma_mask  = 8'h0F;
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        #1 checkCtl("t2_ma_first", 5'b01000);
        nextCycle();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        #1 checkCtl("t2_ma_addr_phase", 5'b00100);
        checkOutput("t2_a_we", 64'(bus.mem_a_we), 64'h1);
        checkOutput("t2_a_addr", bus.mem_a_addr, 64'h1000);
        checkOutput("t2_a_wdata", bus.mem_a_wdata, 64'hDEAD_BEEF);
        checkOutput("t2_a_mask", 64'(bus.mem_a_mask), 64'h0F);
        nextCycle();
        bus.mem_d_data  = 64'h55;
        bus.mem_d_error = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        #1 checkCtl("t2_data_state", 5'b00000);
        nextCycle();
        bus.mem_d_error = 1'b0;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        #1 checkCtl("t2_if_next", 5'b10001);
        checkOutput("t2_rsp_data", bus.rsp_data, 64'h55);
        checkOutput("t2_rsp_err", 64'(bus.rsp_err), 64'h1);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        #1 checkCtl("t2_if_addr_phase", 5'b00100);
        checkOutput("t2_if_a_addr", bus.mem_a_addr, 64'h8000_0004);
        checkOutput("t2_if_a_we", 64'(bus.mem_a_we), 64'h0);
        nextCycle();
        bus.mem_d_data = 64'h77;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1 checkCtl("t2_if_rvalid", 5'b00010);
        checkOutput("t2_if_rsp", bus.rsp_data, 64'h77);
        checkOutput("t2_if_err", 64'(bus.rsp_err), 64'h0);

        $display("[TB] starvation limit");
        bus.ma_we = 1'b0;
        for (int i = 0; i < 6; i++) begin
            nextCycle();
            applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
            #1 checkCtl($sformatf("t3_grant_%0d", i), t3_exp[i]);
            nextCycle();
            applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
            nextCycle();
            bus.mem_d_data = 64'(i);
            applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        end
        nextCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1 checkCtl("t3_last_rvalid", 5'b00001);
        checkOutput("t3_last_rsp", bus.rsp_data, 64'h5);

        $display("[TB] flush during fetch");
        nextCycle();
        bus.if_addr = 64'h8000_0100;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        #1 checkCtl("t4_gnt", 5'b10000);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        #1 checkCtl("t4_data_clear", 5'b00000);
        nextCycle();
        bus.mem_d_data = 64'h99;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        #1 checkCtl("t4_data_resp", 5'b00000);
        nextCycle();
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        #1 checkCtl("t4_no_rvalid_blocked", 5'b00000);
        checkOutput("t4_rsp_data", bus.rsp_data, 64'h99);
        nextCycle();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        #1 checkCtl("t4_regrant", 5'b10000);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        nextCycle();
        bus.mem_d_data = 64'hAB;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1 checkCtl("t4_rvalid_restored", 5'b00010);
        checkOutput("t4_rsp_ab", bus.rsp_data, 64'hAB);
        nextCycle();
        bus.ma_addr = 64'h2000;
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        #1 checkCtl("t4_ma_gnt_clear", 5'b01000);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        nextCycle();
        bus.mem_d_data = 64'hC0;
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        #1 checkCtl("t4_ma_rvalid_clear", 5'b00001);
        checkOutput("t4_ma_rsp", bus.rsp_data, 64'hC0);

        $display("[TB] downstream stall");
        nextCycle();
        bus.ma_we    = 1'b1;
        bus.ma_addr  = 64'h3000;
        bus.ma_wdata = 64'h0123_4567_89AB_CDEF;
        bus.ma_mask  = 8'hA5;
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        #1 checkCtl("t5_gnt", 5'b01000);
        for (int i = 0; i < 5; i++) begin
            nextCycle();
            bus.ma_we      = 1'b0;
            bus.ma_addr    = 64'hFFFF;
            bus.ma_wdata   = '0;
            bus.ma_mask    = '0;
            bus.mem_d_data = 64'hEE;
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
            #1 checkCtl($sformatf("t5_stall_ctl_%0d", i), 5'b00100);
            checkOutput($sformatf("t5_stall_addr_%0d", i), bus.mem_a_addr, 64'h3000);
            checkOutput($sformatf("t5_stall_wdata_%0d", i), bus.mem_a_wdata,
                        64'h0123_4567_89AB_CDEF);
            checkOutput($sformatf("t5_stall_mask_%0d", i), 64'(bus.mem_a_mask), 64'hA5);
            checkOutput($sformatf("t5_stall_we_%0d", i), 64'(bus.mem_a_we), 64'h1);
        end
        nextCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        #1 checkCtl("t5_accept", 5'b00100);
        nextCycle();
        bus.mem_d_data = 64'h5A;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        #1 checkCtl("t5_data", 5'b00000);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1 checkCtl("t5_rvalid", 5'b00001);
        checkOutput("t5_rsp", bus.rsp_data, 64'h5A);

        $display("[TB] reset during address phase");
        nextCycle();
        bus.if_addr = 64'h8000_0200;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        #1 checkCtl("t6_gnt", 5'b10000);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1 checkCtl("t6_addr_phase", 5'b00100);
        rst = 1'b1;
        #1 checkCtl("t6_async_ctl", 5'b00000);
        checkOutput("t6_async_rsp", bus.rsp_data, 64'h0);
        checkOutput("t6_async_a_addr", bus.mem_a_addr, 64'h0);
        checkOutput("t6_async_a_mask", 64'(bus.mem_a_mask), 64'h0);
        for (int i = 0; i < 2; i++) begin
            nextCycle();
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
            #1 checkCtl($sformatf("t6_in_reset_%0d", i), 5'b00000);
        end
        nextCycle();
        bus.ma_we   = 1'b0;
        bus.ma_addr = 64'h4000;
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        rst = 1'b0;
        #1 checkCtl("t6_first_grant", 5'b01000);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        #1 checkCtl("t6_addr_after_reset", 5'b00100);
        checkOutput("t6_a_addr", bus.mem_a_addr, 64'h4000);
        nextCycle();
        bus.mem_d_data = 64'h66;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        #1 checkCtl("t6_data", 5'b00000);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1 checkCtl("t6_ma_rvalid_only", 5'b00001);
        checkOutput("t6_rsp", bus.rsp_data, 64'h66);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
